// File: rtl/cdtimer_pkg.sv
// Shared register map and bit positions for the countdown timer bank.
package cdtimer_pkg;

    localparam logic [1:0] REG_COUNT  = 2'd0;
    localparam logic [1:0] REG_RELOAD = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_SRC        = 2;
    localparam int CTRL_IRQEN      = 3;
    localparam int CTRL_BITS       = 4;

    localparam int STATUS_FLAG = 0;

endpackage

// File: rtl/cdtimer_chan.sv
// One countdown channel: event edge detector, counter with reload, sticky expiry flag.
module cdtimer_chan
    import cdtimer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 sysclk,
    input  logic                 sysreset,
    input  logic                 tick,
    input  logic                 counter_event,
    input  logic                 wr_count,
    input  logic                 wr_reload,
    input  logic                 wr_ctrl,
    input  logic                 wr_status,
    input  logic [WIDTH-1:0]     data_in,
    output logic [WIDTH-1:0]     count,
    output logic [WIDTH-1:0]     reload,
    output logic [CTRL_BITS-1:0] ctrl,
    output logic                 flag
);

    logic event_d;
    logic event_edge;
    logic pulse;
    logic expire;

    assign event_edge = counter_event & ~event_d;
    assign pulse      = ctrl[CTRL_EN] & (ctrl[CTRL_SRC] ? tick : event_edge);
    // A register write to COUNT swallows a coincident pulse, so it cannot expire either.
    assign expire     = pulse & ~wr_count & (count == WIDTH'(1));

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            event_d <= 1'b0;
            count   <= '0;
            reload  <= '0;
            ctrl    <= '0;
            flag    <= 1'b0;
        end else begin
            event_d <= counter_event;

            if (wr_count)
                count <= data_in;
            else if (expire)
                count <= ctrl[CTRL_AUTORELOAD] ? reload : '0;
            else if (pulse && count > WIDTH'(1))
                count <= count - WIDTH'(1);

            if (wr_reload)
                reload <= data_in;
            if (wr_ctrl)
                ctrl <= data_in[CTRL_BITS-1:0];

            if (expire)
                flag <= 1'b1;
            else if (wr_status && data_in[STATUS_FLAG])
                flag <= 1'b0;
        end
    end

endmodule

// File: rtl/cdtimer_bank.sv
// Bank of NCH independent countdown timers sharing one prescaler and a small register file.
module cdtimer_bank
    import cdtimer_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int NCH      = 4,
    parameter int PRESCALE = 50
) (
    input  logic                     sysclk,
    input  logic                     sysreset,
    input  logic [$clog2(NCH)+1:0]   addr,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    input  logic [NCH-1:0]           counter_event,
    output logic [NCH-1:0]           expired,
    output logic                     irq
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW = $clog2(PRESCALE);

    logic [CW-1:0]        ch_sel;
    logic [PW-1:0]        presc;
    logic                 tick;
    logic [WIDTH-1:0]     count_q  [NCH];
    logic [WIDTH-1:0]     reload_q [NCH];
    logic [CTRL_BITS-1:0] ctrl_q   [NCH];
    logic [NCH-1:0]       flag_q;
    logic [NCH-1:0]       irq_src;

    generate
        if (NCH > 1) begin : g_sel
            assign ch_sel = addr[$clog2(NCH)+1:2];
        end else begin : g_sel1
            assign ch_sel = '0;
        end
    endgenerate

    assign tick = (presc == PW'(PRESCALE - 1));

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset)
            presc <= '0;
        else if (tick)
            presc <= '0;
        else
            presc <= presc + PW'(1);
    end

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_chan
            logic sel;
            assign sel = wr_en && (ch_sel == CW'(i));

            cdtimer_chan #(.WIDTH(WIDTH)) u_chan (
                .sysclk        (sysclk),
                .sysreset      (sysreset),
                .tick          (tick),
                .counter_event (counter_event[i]),
                .wr_count      (sel && addr[1:0] == REG_COUNT),
                .wr_reload     (sel && addr[1:0] == REG_RELOAD),
                .wr_ctrl       (sel && addr[1:0] == REG_CTRL),
                .wr_status     (sel && addr[1:0] == REG_STATUS),
                .data_in       (data_in),
                .count         (count_q[i]),
                .reload        (reload_q[i]),
                .ctrl          (ctrl_q[i]),
                .flag          (flag_q[i])
            );

            assign expired[i] = (count_q[i] == '0);
            assign irq_src[i] = flag_q[i] & ctrl_q[i][CTRL_IRQEN];
        end
    endgenerate

    assign irq = |irq_src;

    // Channel indices beyond NCH (non-power-of-two banks) read back as zero.
    always_comb begin
        data_out = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_sel == CW'(i)) begin
                case (addr[1:0])
                    REG_COUNT:  data_out = count_q[i];
                    REG_RELOAD: data_out = reload_q[i];
                    REG_CTRL:   data_out = WIDTH'(ctrl_q[i]);
                    REG_STATUS: data_out = WIDTH'(flag_q[i]);
                    default:    data_out = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cdtimer_bank.sv
// Directed self-checking bench for cdtimer_bank: register table plus multi-cycle corner sequences.
module tb_cdtimer_bank;

    logic        sysclk = 1'b0;
    logic        sysreset = 1'b1;
    logic [3:0]  addr = '0;
    logic        wr_en = 1'b0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic [3:0]  counter_event = '0;
    logic [3:0]  expired;
    logic        irq;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic        we;
        logic [3:0]  a;
        logic [15:0] wdata;
        logic [15:0] exp_data;
        logic [3:0]  exp_expired;
    } vec_t;

    vec_t vecs [8];

    cdtimer_bank #(.WIDTH(16), .NCH(4), .PRESCALE(50)) dut (
        .sysclk        (sysclk),
        .sysreset      (sysreset),
        .addr          (addr),
        .wr_en         (wr_en),
        .data_in       (data_in),
        .data_out      (data_out),
        .counter_event (counter_event),
        .expired       (expired),
        .irq           (irq)
    );

    always #5 sysclk = ~sysclk;

    function automatic logic [3:0] ra(input int ch, input int rg);
        logic [1:0] c;
        logic [1:0] r;
        c = ch[1:0];
        r = rg[1:0];
        return {c, r};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [15:0] d);
        @(negedge sysclk);
        addr = a;
        data_in = d;
        wr_en = 1'b1;
        @(negedge sysclk);
        wr_en = 1'b0;
    endtask

    task automatic readReg(input logic [3:0] a, output logic [15:0] v);
        wr_en = 1'b0;
        addr = a;
        #1;
        v = data_out;
    endtask

    task automatic doReset();
        @(negedge sysclk);
        sysreset = 1'b1;
        repeat (2) @(negedge sysclk);
        sysreset = 1'b0;
    endtask

    task automatic evPulse(input int ch);
        @(negedge sysclk);
        counter_event[ch] = 1'b1;
        @(negedge sysclk);
        counter_event[ch] = 1'b0;
        @(negedge sysclk);
    endtask

    initial begin
        logic [15:0] v;
        int cyc;
        int t1;
        int t4;
        bit found;

        vecs[0] = '{1'b0, ra(0, 0), 16'h0000, 16'h0000, 4'hF};
        vecs[1] = '{1'b1, ra(0, 1), 16'hABCD, 16'hABCD, 4'hF};
        vecs[2] = '{1'b1, ra(2, 2), 16'hFFFA, 16'h000A, 4'hF};
        vecs[3] = '{1'b1, ra(3, 0), 16'h1234, 16'h1234, 4'h7};
        vecs[4] = '{1'b1, ra(1, 3), 16'hFFFF, 16'h0000, 4'h7};
        vecs[5] = '{1'b0, ra(3, 1), 16'h0000, 16'h0000, 4'h7};
        vecs[6] = '{1'b1, ra(1, 0), 16'h0001, 16'h0001, 4'h5};
        vecs[7] = '{1'b0, ra(2, 3), 16'h0000, 16'h0000, 4'h5};

        repeat (2) @(negedge sysclk);
        checkOutput("reset_expired", expired, 4'hF);
        checkOutput("reset_irq", irq, 1'b0);
        sysreset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].we)
                applyStimulus(vecs[i].a, vecs[i].wdata);
            readReg(vecs[i].a, v);
            checkOutput($sformatf("vec%0d_data", i), v, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d_expired", i), expired, vecs[i].exp_expired);
        end

        // One-shot countdown on event edges
        doReset();
        applyStimulus(ra(0, 0), 16'd3);
        applyStimulus(ra(0, 2), 16'h0001);
        for (int k = 0; k < 3; k++) begin
            evPulse(0);
            readReg(ra(0, 0), v);
            checkOutput($sformatf("oneshot_count%0d", k), v, 16'(2 - k));
        end
        checkOutput("oneshot_expired0", expired[0], 1'b1);
        readReg(ra(0, 3), v);
        checkOutput("oneshot_flag", v, 16'h0001);
        checkOutput("oneshot_irq_masked", irq, 1'b0);
        evPulse(0);
        readReg(ra(0, 0), v);
        checkOutput("oneshot_stays_zero", v, 16'h0000);

        // Auto-reload on prescaler ticks
        doReset();
        cyc = 0;
        applyStimulus(ra(1, 1), 16'd4);
        applyStimulus(ra(1, 0), 16'd2);
        applyStimulus(ra(1, 2), 16'h000F);
        readReg(ra(1, 0), v);
        found = 0;
        t1 = 0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge sysclk);
            #1;
            cyc++;
            if (data_out == 16'd1) begin
                found = 1;
                t1 = cyc;
            end
        end
        checkOutput("auto_first_tick_seen", found, 1'b1);
        found = 0;
        t4 = 0;
        for (int n = 0; n < 70 && !found; n++) begin
            @(negedge sysclk);
            #1;
            cyc++;
            if (data_out != 16'd1) begin
                found = 1;
                t4 = cyc;
            end
        end
        checkOutput("auto_reload_value", data_out, 16'd4);
        checkOutput("auto_tick_interval", t4 - t1, 50);
        checkOutput("auto_irq_set", irq, 1'b1);
        applyStimulus(ra(1, 3), 16'h0001);
        #1;
        checkOutput("auto_irq_cleared", irq, 1'b0);

        // Write beats same-cycle event edge
        applyStimulus(ra(2, 0), 16'd10);
        applyStimulus(ra(2, 2), 16'h0001);
        @(negedge sysclk);
        addr = ra(2, 0);
        data_in = 16'd7;
        wr_en = 1'b1;
        counter_event[2] = 1'b1;
        @(negedge sysclk);
        wr_en = 1'b0;
        counter_event[2] = 1'b0;
        readReg(ra(2, 0), v);
        checkOutput("prio_write_wins", v, 16'd7);
        evPulse(2);
        readReg(ra(2, 0), v);
        checkOutput("prio_next_edge", v, 16'd6);

        // Expiry set wins over same-cycle clear
        applyStimulus(ra(2, 0), 16'd1);
        @(negedge sysclk);
        addr = ra(2, 3);
        data_in = 16'h0001;
        wr_en = 1'b1;
        counter_event[2] = 1'b1;
        @(negedge sysclk);
        wr_en = 1'b0;
        counter_event[2] = 1'b0;
        readReg(ra(2, 3), v);
        checkOutput("setclr_flag", v, 16'h0001);
        readReg(ra(2, 0), v);
        checkOutput("setclr_count", v, 16'h0000);
        applyStimulus(ra(2, 3), 16'h0001);
        readReg(ra(2, 3), v);
        checkOutput("plain_clear", v, 16'h0000);

        // Held-high event counts once
        applyStimulus(ra(3, 0), 16'd10);
        applyStimulus(ra(3, 2), 16'h0001);
        @(negedge sysclk);
        counter_event[3] = 1'b1;
        repeat (20) @(negedge sysclk);
        counter_event[3] = 1'b0;
        repeat (3) @(negedge sysclk);
        readReg(ra(3, 0), v);
        checkOutput("level_one_decrement", v, 16'd9);

        // Reset while counting
        applyStimulus(ra(0, 0), 16'd100);
        applyStimulus(ra(0, 2), 16'h0005);
        repeat (75) @(negedge sysclk);
        sysreset = 1'b1;
        #1;
        checkOutput("midrst_expired", expired, 4'hF);
        checkOutput("midrst_irq", irq, 1'b0);
        repeat (2) @(negedge sysclk);
        sysreset = 1'b0;
        cyc = 0;
        for (int r = 0; r < 16; r++) begin
            @(negedge sysclk);
            cyc++;
            addr = 4'(r);
            #1;
            checkOutput($sformatf("midrst_reg%0d", r), data_out, 16'h0000);
        end
        checkOutput("postrst_expired", expired, 4'hF);
        checkOutput("postrst_irq", irq, 1'b0);
        @(negedge sysclk);
        cyc++;
        addr = ra(0, 0);
        data_in = 16'd2;
        wr_en = 1'b1;
        @(negedge sysclk);
        cyc++;
        addr = ra(0, 2);
        data_in = 16'h0005;
        @(negedge sysclk);
        cyc++;
        wr_en = 1'b0;
        addr = ra(0, 0);
        #1;
        checkOutput("postrst_count_loaded", data_out, 16'd2);
        found = 0;
        t1 = 0;
        while (cyc < 80 && !found) begin
            @(negedge sysclk);
            cyc++;
            #1;
            if (data_out != 16'd2) begin
                found = 1;
                t1 = cyc;
            end
        end
        checkOutput("postrst_first_tick_cycle", t1, 50);
        checkOutput("postrst_first_tick_value", data_out, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cdtimer_bank.md
CDTIMER_BANK -- requirements
Module: cdtimer_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 16: counter/data width in bits.
REQ-002 SHALL have parameter NCH, default 4: number of channels, range 1..16.
REQ-003 SHALL have parameter PRESCALE, default 50: sysclk cycles per internal tick, minimum 2.
REQ-004 SHALL have port sysclk, input, 1: clock, all logic on its rising edge.
REQ-005 SHALL have port sysreset, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port addr, input, $clog2(NCH)+2: addr[1:0] selects the register, upper bits select the channel.
REQ-007 SHALL have port wr_en, input, 1: write strobe for the addressed register.
REQ-008 SHALL have port data_in, input, WIDTH: write data.
REQ-009 SHALL have port data_out, output, WIDTH: read data for addr, combinational, zero latency.
REQ-010 SHALL have port counter_event, input, NCH: per-channel external count source.
REQ-011 SHALL have port expired, output, NCH: expired[i] = (COUNT[i] == 0).
REQ-012 SHALL have port irq, output, 1: OR over channels of (FLAG & IRQEN).

Function
REQ-013 SHALL provide per-channel registers: 0 COUNT (r/w), 1 RELOAD (r/w), 2 CTRL (r/w), 3 STATUS (r, write-1-to-clear).
REQ-014 SHALL define CTRL bits: 0 EN, 1 AUTORELOAD, 2 SRC (0 = counter_event rising edge, 1 = prescaler tick), 3 IRQEN; upper bits SHALL read 0.
REQ-015 SHALL define STATUS bit 0 as FLAG (sticky expiry); upper bits SHALL read 0.
REQ-016 SHALL detect a per-channel rising edge as counter_event[i] high while its one-cycle-delayed copy is low; edges SHALL be detected whether or not EN is set.
REQ-017 SHALL run one shared prescaler that counts 0..PRESCALE-1 and pulses the tick for one cycle at PRESCALE-1.
REQ-018 SHALL decrement channel i by 1 on a selected count pulse when EN=1 and COUNT>1.
REQ-019 SHALL handle a count pulse at COUNT=1 as follows: set FLAG; with AUTORELOAD=1, load RELOAD; otherwise load 0.
REQ-020 SHALL ignore count pulses when COUNT=0, including with AUTORELOAD=1 (no reload from 0).
REQ-021 SHALL load COUNT from data_in on a COUNT write; a write SHALL override a same-cycle count pulse, and that pulse SHALL be lost.
REQ-022 SHALL give a same-cycle FLAG set priority over a STATUS write-1 clear.
REQ-023 SHALL treat RELOAD=0 with AUTORELOAD=1 as one-shot: the channel ends at COUNT=0.
REQ-024 SHALL keep channels fully independent apart from the shared prescaler.

Reset
REQ-025 SHALL clear on sysreset: all COUNT, RELOAD, CTRL, FLAG, edge-detector history and the prescaler to 0.
REQ-026 SHALL therefore drive expired all-ones and irq=0 during and after reset.
REQ-027 SHALL return the prescaler to 0 on a reset asserted mid-count, with the first tick PRESCALE cycles after release.

Structure
REQ-028 SHALL place register offsets (COUNT, RELOAD, CTRL, STATUS) and CTRL/STATUS bit indices in shared package cdtimer_pkg.
REQ-029 SHALL implement one channel (edge detector, counter, reload, flag) as sub-module cdtimer_chan, instantiated NCH times by generate.

Verification
REQ-030 SHALL verify one-shot operation: ch0 COUNT=3, CTRL=EN|SRC=0, three counter_event pulses -> COUNT 2,1,0; expired[0]=1, FLAG=1; a fourth pulse leaves COUNT=0.
REQ-031 SHALL verify auto-reload: ch1 RELOAD=4, COUNT=2, CTRL=EN|AUTORELOAD|SRC|IRQEN -> ticks every 50 cycles; after the 2nd tick COUNT=4 and irq=1; after a STATUS write of 1, irq=0.
REQ-032 SHALL verify write priority: a COUNT write of 7 in the same cycle as an event edge on ch2 -> COUNT=7 next cycle, not 6.
REQ-033 SHALL verify set-over-clear: a STATUS clear in the expiry cycle -> FLAG remains 1.
REQ-034 SHALL verify level-input immunity: counter_event[3] held high for 20 cycles -> exactly one decrement.
REQ-035 SHALL verify reset mid-run: assert sysreset while channels count -> all registers 0, expired all-ones, irq=0, first tick exactly 50 cycles after release.
